// File: rtl/aes_stream_pkg.sv
// Shared types and constants for the AES result stream path.
package aes_stream_pkg;

  // Drain FSM encoding
  typedef enum logic [1:0] {
    DRAIN_IDLE   = 2'd0,
    DRAIN_STREAM = 2'd1,
    DRAIN_FLUSH  = 2'd2
  } drain_state_e;

  // Skid buffer depth and the width needed to count 0..SKID_DEPTH entries
  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);
  localparam int IDX_W      = $clog2(SKID_DEPTH);

endpackage

// File: rtl/axis_skid_buffer.sv
// Small in-order buffer presenting pushed words as an AXI4-Stream master.
// The producer is responsible for never pushing into a full buffer.
module axis_skid_buffer
  import aes_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [OCC_W-1:0]      occ,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  logic [SKID_DEPTH-1:0][DATA_WIDTH-1:0] ent;
  logic                                  pop;
  logic [IDX_W-1:0]                      wr_idx;

  assign m_axis_tvalid = (occ != '0);
  assign m_axis_tdata  = ent[0];
  assign pop           = m_axis_tvalid & m_axis_tready;
  // A same-cycle pop shifts everything down, so the write slot moves with it
  assign wr_idx        = IDX_W'(occ - OCC_W'(pop));

  // Entry storage and occupancy; head stays put until its handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent <= '0;
      occ <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < SKID_DEPTH - 1; i++) ent[i] <= ent[i+1];
      end
      if (push) ent[wr_idx] <= push_data;
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
    end
  end

endmodule

// File: rtl/fifo_axis_drain.sv
// Drains a length-commanded packet from the result FIFO (1-cycle read
// latency) onto an AXI4-Stream master with tlast, via a 2-entry skid buffer.
module fifo_axis_drain
  import aes_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  input  logic                  fifo_ready,
  output logic                  fifo_read_e,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done
);

  drain_state_e         state, state_nxt;
  logic [LEN_WIDTH-1:0] rd_left, beat_left;
  logic [OCC_W-1:0]     occ;
  logic                 inflight;
  logic                 live;
  logic                 hs;
  logic                 credit_ok;
  logic                 cmd_acc;

  assign hs           = m_axis_tvalid & m_axis_tready;
  assign m_axis_tlast = m_axis_tvalid & (beat_left == LEN_WIDTH'(1));
  assign cmd_acc      = cmd_valid & cmd_ready;
  // Words already buffered plus the one returning from the FIFO this cycle
  assign credit_ok    = ((OCC_W+1)'(occ) + (OCC_W+1)'(inflight)) < (OCC_W+1)'(SKID_DEPTH);

  // Next-state and command/read strobes
  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    fifo_read_e = 1'b0;
    busy        = 1'b0;
    case (state)
      DRAIN_IDLE: begin
        cmd_ready = live;
        if (cmd_valid && live && cmd_len != '0) state_nxt = DRAIN_STREAM;
      end
      DRAIN_STREAM: begin
        busy        = 1'b1;
        fifo_read_e = (rd_left != '0) & ~fifo_empty & fifo_ready & credit_ok;
        if (rd_left == '0 || (rd_left == LEN_WIDTH'(1) && fifo_read_e)) state_nxt = DRAIN_FLUSH;
      end
      DRAIN_FLUSH: begin
        // busy falls in the same cycle done pulses
        busy = (beat_left != '0);
        if (beat_left == '0) state_nxt = DRAIN_IDLE;
      end
      default: state_nxt = DRAIN_IDLE;
    endcase
  end

  // State register; live holds cmd_ready low until the first cycle out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= DRAIN_IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  // Read/beat counters, read-in-flight flag and done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_left   <= '0;
      beat_left <= '0;
      inflight  <= 1'b0;
      done      <= 1'b0;
    end else begin
      inflight <= fifo_read_e;
      done     <= (hs & m_axis_tlast) | (cmd_acc & (cmd_len == '0));
      if (cmd_acc && cmd_len != '0) begin
        rd_left   <= cmd_len;
        beat_left <= cmd_len;
      end else begin
        if (fifo_read_e) rd_left   <= rd_left - LEN_WIDTH'(1);
        if (hs)          beat_left <= beat_left - LEN_WIDTH'(1);
      end
    end
  end

  axis_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk          (clk),
    .reset        (reset),
    .push         (inflight),
    .push_data    (fifo_rdata),
    .occ          (occ),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

endmodule

// File: tb/tb_fifo_axis_drain.sv
// Scoreboard bench for fifo_axis_drain: a queue-based FIFO model feeds the
// DUT, packets push expected beats, and a monitor checks every handshake.
module tb_fifo_axis_drain;

  localparam int DW = 128;
  localparam int LW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_ready = 1'b1;
  logic          fifo_read_e;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          busy;
  logic          done;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] feed_q[$];

  int checks = 0;
  int errors = 0;
  int feed_period = 1;
  int feed_cnt = 0;
  int tr_mode = 0;
  int tr_idx = 0;
  bit fr_rand = 1'b0;
  bit fr_force = 1'b0;
  int hs_cnt = 0;

  fifo_axis_drain #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_len      (cmd_len),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .fifo_rdata   (fifo_rdata),
    .fifo_empty   (fifo_empty),
    .fifo_ready   (fifo_ready),
    .fifo_read_e  (fifo_read_e),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data, writes trickle in from feed_q
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_q.delete();
      fifo_rdata <= '0;
      fifo_empty <= 1'b1;
      feed_cnt = 0;
    end else begin
      if (fifo_read_e) begin
        if (fifo_q.size() != 0) fifo_rdata <= fifo_q.pop_front();
        else fifo_rdata <= '0;
      end
      if (feed_cnt > 0) feed_cnt--;
      else if (feed_q.size() != 0) begin
        fifo_q.push_back(feed_q.pop_front());
        feed_cnt = feed_period - 1;
      end
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // tready pattern and fifo_ready generator
  always @(posedge clk) begin
    #1;
    case (tr_mode)
      0: m_axis_tready = 1'b1;
      1: begin
        m_axis_tready = (tr_idx % 4 == 0) || (tr_idx % 4 == 3);
        tr_idx++;
      end
      default: m_axis_tready = ($urandom_range(0, 2) != 0);
    endcase
    fifo_ready = fr_force ? 1'b0 : (fr_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  // Monitor: beats, done timing, stall stability, read gating
  bit            done_exp = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int            outstanding = 0;
  beat_t         mb;
  bit            mhs;

  always @(negedge clk) begin
    if (!reset) begin
      done_exp    = 1'b0;
      prev_stall  = 1'b0;
      outstanding = 0;
    end else begin
      if (done || done_exp) begin
        checks++;
        if (done !== done_exp) begin
          errors++;
          $display("FAIL done got %0b exp %0b t=%0t", done, done_exp, $time);
        end
      end
      if (done) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_done got %0b exp 0 t=%0t", busy, $time);
        end
      end
      if (prev_stall) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data) begin
          errors++;
          $display("FAIL stall_stable got v=%0b d=%h exp v=1 d=%h", m_axis_tvalid, m_axis_tdata, prev_data);
        end
      end
      if (fifo_read_e) begin
        checks++;
        if (fifo_empty || !fifo_ready || outstanding >= 2) begin
          errors++;
          $display("FAIL read_gate got empty=%0b ready=%0b outstanding=%0d exp 0/1/<2", fifo_empty, fifo_ready, outstanding);
        end
      end
      if (m_axis_tvalid && exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_beat got tvalid=1 data=%h exp no beat", m_axis_tdata);
      end
      mhs      = m_axis_tvalid && m_axis_tready;
      done_exp = 1'b0;
      if (mhs && exp_q.size() != 0) begin
        mb = exp_q.pop_front();
        checks++;
        if (m_axis_tdata !== mb.data || m_axis_tlast !== mb.last) begin
          errors++;
          $display("FAIL beat got d=%h l=%0b exp d=%h l=%0b", m_axis_tdata, m_axis_tlast, mb.data, mb.last);
        end
        done_exp = mb.last;
        hs_cnt++;
      end
      if (cmd_valid && cmd_ready && cmd_len == '0) done_exp = 1'b1;
      outstanding += int'(fifo_read_e) - int'(mhs);
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_ready"}, DW'(cmd_ready), '0);
    chk({tag, "_fifo_read_e"}, DW'(fifo_read_e), '0);
    chk({tag, "_tvalid"}, DW'(m_axis_tvalid), '0);
    chk({tag, "_tlast"}, DW'(m_axis_tlast), '0);
    chk({tag, "_tdata"}, m_axis_tdata, '0);
    chk({tag, "_busy"}, DW'(busy), '0);
    chk({tag, "_done"}, DW'(done), '0);
  endtask

  // Build a packet, feed its words to the FIFO and issue the command
  task automatic run_pkt(input int len, input int period, input bit preload, input bit seq);
    logic [DW-1:0] w[$];
    int            t;
    bit            acc;
    for (int i = 0; i < len; i++)
      w.push_back(seq ? DW'(i + 1) : {$urandom, $urandom, $urandom, $urandom});
    feed_period = period;
    if (preload) begin
      foreach (w[i]) feed_q.push_back(w[i]);
      repeat (len * period + 3) @(posedge clk);
    end
    @(posedge clk);
    #1;
    cmd_len   = LW'(len);
    cmd_valid = 1'b1;
    t   = 0;
    acc = 1'b0;
    while (!acc && t < 200) begin
      @(negedge clk);
      if (cmd_ready) acc = 1'b1;
      else t++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL cmd_accept got timeout exp cmd_ready within 200 cycles");
    end else begin
      foreach (w[i]) exp_q.push_back('{w[i], (i == len - 1)});
      if (!preload) foreach (w[i]) feed_q.push_back(w[i]);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy || feed_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout got %0d beats pending exp 0 within %0d cycles", exp_q.size(), budget);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int base;
    int t;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    reset = 1'b1;

    // Basic packet 0x1..0x4
    tr_mode = 0;
    run_pkt(4, 1, 1'b1, 1'b1);
    wait_idle(200);

    // Backpressure 1,0,0,1
    tr_mode = 1;
    tr_idx  = 0;
    run_pkt(8, 1, 1'b1, 1'b0);
    wait_idle(300);

    // Starved FIFO, one word every 5 cycles
    tr_mode = 0;
    run_pkt(3, 5, 1'b0, 1'b0);
    wait_idle(300);

    // fifo_ready held low for 2 cycles mid-packet
    run_pkt(8, 1, 1'b1, 1'b0);
    @(negedge clk);
    fr_force = 1'b1;
    repeat (2) @(negedge clk);
    fr_force = 1'b0;
    wait_idle(300);

    // Edge lengths
    run_pkt(0, 1, 1'b0, 1'b0);
    wait_idle(50);
    run_pkt(1, 1, 1'b1, 1'b0);
    wait_idle(50);
    tr_mode = 2;
    run_pkt(511, 1, 1'b0, 1'b0);
    wait_idle(5000);

    // Random packets with random backpressure and fifo_ready
    fr_rand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      run_pkt($urandom_range(1, 24), $urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'b0);
      wait_idle(2000);
    end
    fr_rand = 1'b0;

    // Reset after beat 2 of 6
    tr_mode = 0;
    base = hs_cnt;
    run_pkt(6, 1, 1'b1, 1'b0);
    t = 0;
    while (hs_cnt < base + 2 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (hs_cnt < base + 2) begin
      errors++;
      $display("FAIL mid_reset_wait got %0d beats exp 2", hs_cnt - base);
    end
    #1;
    reset = 1'b0;
    exp_q.delete();
    feed_q.delete();
    #1;
    check_reset("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    run_pkt(2, 1, 1'b1, 1'b0);
    wait_idle(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
